// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes the ID opcode, carries a control word down NSTG
// stages, and drives dm_we/rf_we with RAW hazard stall, flush and perf counters.
module pipe_ctrl_unit #(
  parameter int OP_W   = 6,
  parameter int RA_W   = 5,
  parameter int NSTG   = 3,
  parameter int DM_STG = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [OP_W-1:0]  id_opcode,
  input  logic [RA_W-1:0]  id_rd,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             flush,
  output logic             id_ready,
  output logic             rf_we,
  output logic [RA_W-1:0]  rf_waddr,
  output logic             dm_we,
  output logic             illegal,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  if (NSTG < 2 || NSTG > 8) begin : g_bad_nstg
    $error("pipe_ctrl_unit: NSTG out of range");
  end
  if (DM_STG < 0 || DM_STG > NSTG - 2) begin : g_bad_dm
    $error("pipe_ctrl_unit: DM_STG out of range");
  end

  localparam int OP_NOP   = 0;
  localparam int OP_STORE = 3;
  localparam int OP_MAX   = 20;

  // Control word kept as parallel per-field shift registers; dm only travels
  // as far as the stage that consumes it.
  logic [NSTG-1:0]           vld_pipe;
  logic [NSTG-1:0]           rf_pipe;
  logic [NSTG-1:0][RA_W-1:0] rd_pipe;
  logic [DM_STG:0]           dm_pipe;

  logic [31:0] op_ext;
  logic        is_nop, is_store, is_ill, reads_rs;
  logic        dec_rf, dec_dm;
  logic        hazard, accept;
  logic [NSTG-2:0] hit;

  assign op_ext   = 32'(id_opcode);
  assign is_nop   = (op_ext == OP_NOP);
  assign is_store = (op_ext == OP_STORE);
  assign is_ill   = (op_ext > OP_MAX);
  assign reads_rs = ~is_nop & ~is_ill;
  assign dec_rf   = reads_rs & ~is_store;
  assign dec_dm   = is_store;

  // Final stage is excluded: the register file writes in the first half-cycle.
  for (genvar k = 0; k < NSTG - 1; k++) begin : g_haz
    assign hit[k] = vld_pipe[k] & rf_pipe[k] & (|rd_pipe[k]) &
                    ((rd_pipe[k] == id_rs1) | (rd_pipe[k] == id_rs2));
  end

  assign hazard   = reads_rs & (|hit);
  assign id_ready = ~hazard;
  assign accept   = id_valid & ~hazard & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe   <= '0;
      rf_pipe    <= '0;
      rd_pipe    <= '0;
      dm_pipe    <= '0;
      illegal    <= 1'b0;
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      vld_pipe[0] <= accept;
      rf_pipe[0]  <= dec_rf;
      rd_pipe[0]  <= id_rd;
      dm_pipe[0]  <= dec_dm;
      // Stages below DM_STG are uncommitted and die on flush as they shift.
      for (int k = 1; k < NSTG; k++) begin
        vld_pipe[k] <= vld_pipe[k-1] & ~(flush && (k - 1) < DM_STG);
        rf_pipe[k]  <= rf_pipe[k-1];
        rd_pipe[k]  <= rd_pipe[k-1];
      end
      for (int k = 1; k <= DM_STG; k++) begin
        dm_pipe[k] <= dm_pipe[k-1];
      end
      illegal <= accept & is_ill;
      if (vld_pipe[NSTG-1])
        retire_cnt <= retire_cnt + CNT_W'(1);
      if (id_valid & hazard & ~flush)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign dm_we    = vld_pipe[DM_STG] & dm_pipe[DM_STG];
  assign rf_we    = vld_pipe[NSTG-1] & rf_pipe[NSTG-1];
  assign rf_waddr = rd_pipe[NSTG-1];

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Parametrised pipelined control unit for the RISC CPU.
- Decodes the opcode presented at the decode (ID) stage and carries a control word (valid, rf, dm, rd) through NSTG registered stages.
- Drives the data-memory write enable (dm_we) at the memory stage and the register-file write enable (rf_we) at the final write-back stage.
- Adds RAW hazard detection with issue stall, pipeline flush, illegal-opcode flagging and retire/stall counters.

Parameters:
- OP_W, 6, opcode width.
- RA_W, 5, register address width.
- NSTG, 3, control stages after ID (EX, MEM, WB); legal range 2..8.
- DM_STG, 1, stage index (0-based) at which dm_we is driven; legal range 0..NSTG-2.
- CNT_W, 32, width of the performance counters.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- id_valid, input, 1, an instruction is present at ID.
- id_opcode, input, OP_W, opcode at ID.
- id_rd, input, RA_W, destination register.
- id_rs1, input, RA_W, source register 1.
- id_rs2, input, RA_W, source register 2.
- flush, input, 1, squash the ID instruction and uncommitted in-flight instructions.
- id_ready, output, 1, low while ID is stalled by a hazard.
- rf_we, output, 1, register-file write enable (final stage).
- rf_waddr, output, RA_W, register-file write address (final stage rd).
- dm_we, output, 1, data-memory write enable (stage DM_STG).
- illegal, output, 1, one-cycle pulse when an illegal opcode is accepted.
- retire_cnt, output, CNT_W, count of instructions with valid=1 leaving the final stage.
- stall_cnt, output, CNT_W, count of cycles with id_valid=1 and id_ready=0.

Behaviour:
- Reset (asynchronous, active-high): all stage valid bits = 0; rf_we = 0, dm_we = 0, rf_waddr = 0, illegal = 0, both counters = 0; id_ready = 1 while stages are empty. Reset mid-operation discards all in-flight instructions immediately, with no write enables after reset asserts.
- Decode, combinational at ID:
  - Opcode 0: NOP, rf=0, dm=0.
  - Opcode 3: store, rf=0, dm=1.
  - Opcodes 1, 2, 4..20: rf=1, dm=0.
  - Opcodes 21..2^OP_W-1: illegal, rf=0, dm=0.
  - Every non-NOP, legal opcode reads rs1 and rs2.
- Hazard, combinational:
  - hazard = 1 if a legal, non-NOP ID instruction has rs1 or rs2 equal to the rd of any stage k in 0..NSTG-2 with valid=1, rf=1 and rd != 0.
  - The final stage is excluded: the register file writes in the first half-cycle.
  - Register 0 never causes a hazard.
- id_ready = ~hazard.
- accept = id_valid & ~hazard & ~flush.
- Advance, every clock:
  - stage[k+1] <= stage[k] for all k.
  - stage[0] <= decoded word with valid = accept; a bubble (valid=0) is inserted on a stall or flush.
  - The pipeline never freezes; a stall only blocks ID.
- Flush: valid bits of stages 0..DM_STG-1 are cleared in the same clock edge that shifts the pipeline. Stages at or beyond DM_STG are considered committed and complete normally. When flush and hazard coincide, flush wins and no instruction is accepted.
- Outputs, taken directly from stage registers with no extra latency:
  - dm_we = stage[DM_STG].valid & dm.
  - rf_we = stage[NSTG-1].valid & rf.
  - rf_waddr = stage[NSTG-1].rd.
- Latency: for an instruction accepted in cycle t, dm_we is high in cycle t+1+DM_STG and rf_we is high in cycle t+NSTG.
- illegal is registered: it is high in cycle t+1 for an illegal opcode accepted in cycle t.
- Counters:
  - retire_cnt increments when stage[NSTG-1].valid = 1; NOP and illegal instructions count as retired.
  - stall_cnt increments when id_valid & hazard & ~flush.
  - Both wrap modulo 2^CNT_W.

Test Plan:
- Reset: assert reset mid-stream with three instructions in flight -> rf_we, dm_we, illegal and counters = 0 immediately; id_ready = 1; no write enable after reset is released.
- Write-enable timing: opcode 5, rd=7 accepted at cycle 0 -> rf_we = 1 and rf_waddr = 7 in cycle 3 only. Opcode 3 accepted at cycle 0 -> dm_we = 1 in cycle 2 only; rf_we is never asserted.
- Hazard stall: opcode 1 rd=4 at cycle 0, then opcode 2 rs1=4 at cycle 1 -> id_ready = 0 in cycles 1-2, accepted in cycle 3; stall_cnt = 2. Repeat with rd=0 -> no stall.
- Flush: opcode 4 rd=9 accepted at cycle 0, flush pulsed in cycle 1 (DM_STG=1) -> the instruction is squashed and rf_we stays 0. The same flush with the instruction accepted at cycle -1 (already at stage 1) -> rf_we is still asserted in cycle 2.
- Illegal and NOP: opcode 40 accepted -> illegal pulses for one cycle; no rf_we or dm_we; retire_cnt increments by 1 three cycles later. Opcode 0 -> no enables and no hazard.
- Parameter sweep: NSTG=5, DM_STG=3, CNT_W=4 -> rf_we at t+5, dm_we at t+4; hazard window covers stages 0..3; retire_cnt wraps from 15 to 0 after the 16th retirement.
